// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave with NREG 32-bit registers, one-deep AW/W buffers and byte-lane writes.
// Define AXIL_SLAVE_REGFILE_PROT_EN to reject non-secure (AxPROT[1]=1) accesses with SLVERR.
module axil_slave_regfile #(
  parameter int          NREG      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1111_1100
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP
);

  localparam int IW = $clog2(NREG);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NREG-1:0][31:0] regs;
  logic                  ready_en;
  logic                  aw_full;
  logic [31:2]           aw_addr;
  logic                  w_full;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  logic aw_hs, w_hs, ar_hs, commit;
  logic wr_hit, rd_hit;
  logic [IW-1:0] wr_idx, rd_idx;

  function automatic logic addr_hit(input logic [31:2] a);
    return a[31:IW+2] == BASE_ADDR[31:IW+2];
  endfunction

`ifdef AXIL_SLAVE_REGFILE_PROT_EN
  logic aw_nonsec;
  assign wr_hit = addr_hit(aw_addr) && !aw_nonsec;
  assign rd_hit = addr_hit(ARADDR[31:2]) && !ARPROT[1];
`else
  assign wr_hit = addr_hit(aw_addr);
  assign rd_hit = addr_hit(ARADDR[31:2]);
`endif

  // Sub-word address bits and unused protection bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR[1:0], ARADDR[1:0], AWPROT, ARPROT};

  assign wr_idx  = aw_addr[IW+1:2];
  assign rd_idx  = ARADDR[IW+1:2];

  assign AWREADY = ready_en && !aw_full;
  assign WREADY  = ready_en && !w_full;
  assign ARREADY = ready_en && !rvalid;

  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign ar_hs   = ARVALID && ARREADY;
  assign commit  = aw_full && w_full && !bvalid;

  assign BVALID  = bvalid;
  assign BRESP   = bresp;
  assign RVALID  = rvalid;
  assign RDATA   = rdata;
  assign RRESP   = rresp;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs     <= '0;
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      aw_addr  <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
`ifdef AXIL_SLAVE_REGFILE_PROT_EN
      aw_nonsec <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR[31:2];
`ifdef AXIL_SLAVE_REGFILE_PROT_EN
        aw_nonsec <= AWPROT[1];
`endif
      end

      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end

      // Commit only while no response is pending; handshakes cannot collide
      // with it because a full buffer deasserts its READY.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        if (wr_hit) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end else if (bvalid && BREADY) begin
        bvalid <= 1'b0;
      end

      // Reads sample regs before this edge's commit lands, so a same-edge
      // write to the same register returns the old value.
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_hit ? regs[rd_idx] : 32'h0;
        rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed self-checking bench for axil_slave_regfile using immediate assertions.
module tb_axil_slave_regfile;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]  resp;
  logic [31:0] data;

  always #5 ACLK = ~ACLK;

  axil_slave_regfile dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic [1:0] r);
    logic awd, wd, got, ah, wh;
    @(negedge ACLK);
    AWADDR = a; AWPROT = p; AWVALID = 1'b1;
    WDATA  = d; WSTRB  = s; WVALID  = 1'b1;
    awd = 1'b0; wd = 1'b0; got = 1'b0; r = 2'b11;
    for (int i = 0; i < 20 && !(awd && wd); i++) begin
      ah = AWVALID && AWREADY;
      wh = WVALID && WREADY;
      @(negedge ACLK);
      if (ah) begin AWVALID = 1'b0; awd = 1'b1; end
      if (wh) begin WVALID = 1'b0; wd = 1'b1; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_handshake", {30'd0, awd, wd}, 32'd3);
    for (int i = 0; i < 20 && !got; i++) begin
      if (BVALID) got = 1'b1;
      else @(negedge ACLK);
    end
    chk("wr_bvalid_seen", {31'd0, got}, 32'd1);
    if (got) begin
      r = BRESP;
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [2:0] p,
                          output logic [31:0] d, output logic [1:0] r);
    logic done;
    @(negedge ACLK);
    ARADDR = a; ARPROT = p; ARVALID = 1'b1;
    done = 1'b0; d = 32'hx; r = 2'b11;
    for (int i = 0; i < 20 && !done; i++) begin
      done = ARREADY;
      @(negedge ACLK);
    end
    ARVALID = 1'b0;
    chk("rd_rvalid", {31'd0, done && RVALID}, 32'd1);
    d = RDATA; r = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    AWVALID = 0; AWADDR = 0; AWPROT = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_awready", {31'd0, AWREADY}, 0);
    chk("rst_wready",  {31'd0, WREADY},  0);
    chk("rst_arready", {31'd0, ARREADY}, 0);
    chk("rst_bvalid",  {31'd0, BVALID},  0);
    chk("rst_rvalid",  {31'd0, RVALID},  0);
    ARESETn = 1'b1;
    #1 chk("rel_awready_first", {31'd0, AWREADY}, 0);
    @(negedge ACLK);
    chk("rel_awready_second", {31'd0, AWREADY}, 1);
    chk("rel_arready_second", {31'd0, ARREADY}, 1);

    // AW and W in the same cycle; BVALID one edge after the handshake
    AWADDR = 32'h1111_1104; AWVALID = 1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1;
    chk("same_wready", {31'd0, WREADY}, 1);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    chk("same_bvalid_early", {31'd0, BVALID}, 0);
    chk("same_awready_full", {31'd0, AWREADY}, 0);
    @(negedge ACLK);
    chk("same_bvalid", {31'd0, BVALID}, 1);
    chk("same_bresp", {30'd0, BRESP}, 0);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    chk("same_bvalid_clear", {31'd0, BVALID}, 0);
    axi_read(32'h1111_1104, 3'b000, data, resp);
    chk("rd1_data", data, 32'hDEAD_BEEF);
    chk("rd1_resp", {30'd0, resp}, 0);

    // W first, AW three cycles later, partial strobes
    @(negedge ACLK);
    WDATA = 32'hAABB_CCDD; WSTRB = 4'b0101; WVALID = 1;
    chk("wfirst_wready", {31'd0, WREADY}, 1);
    @(negedge ACLK);
    WVALID = 0;
    for (int i = 0; i < 2; i++) begin
      chk("wfirst_no_b", {31'd0, BVALID}, 0);
      @(negedge ACLK);
    end
    AWADDR = 32'h1111_1100; AWVALID = 1;
    chk("wfirst_no_b_c3", {31'd0, BVALID}, 0);
    @(negedge ACLK);
    AWVALID = 0;
    chk("wfirst_no_b_hs", {31'd0, BVALID}, 0);
    @(negedge ACLK);
    chk("wfirst_bvalid", {31'd0, BVALID}, 1);
    chk("wfirst_bresp", {30'd0, BRESP}, 0);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    axi_read(32'h1111_1100, 3'b000, data, resp);
    chk("strb_data", data, 32'h00BB_00DD);

    // Misses and decode boundaries
    axi_write(32'h2222_0000, 32'hFFFF_FFFF, 4'hF, 3'b000, resp);
    chk("miss_bresp", {30'd0, resp}, 2);
    axi_read(32'h1111_1100, 3'b000, data, resp);
    chk("miss_reg0", data, 32'h00BB_00DD);
    axi_read(32'h1111_1104, 3'b000, data, resp);
    chk("miss_reg1", data, 32'hDEAD_BEEF);
    axi_read(32'h2222_0000, 3'b000, data, resp);
    chk("miss_rdata", data, 0);
    chk("miss_rresp", {30'd0, resp}, 2);
    axi_write(32'h1111_111C, 32'h9999_9999, 4'h0, 3'b000, resp);
    chk("strb0_bresp", {30'd0, resp}, 0);
    axi_read(32'h1111_111C, 3'b000, data, resp);
    chk("strb0_data", data, 0);
    axi_write(32'h1111_111C, 32'h1234_5678, 4'hF, 3'b000, resp);
    axi_write(32'h1111_10FC, 32'h0, 4'hF, 3'b000, resp);
    chk("below_base_bresp", {30'd0, resp}, 2);
    axi_read(32'h1111_111C, 3'b000, data, resp);
    chk("reg7_data", data, 32'h1234_5678);
    axi_read(32'h1111_1120, 3'b000, data, resp);
    chk("past_end_rresp", {30'd0, resp}, 2);
    chk("past_end_rdata", data, 0);
    axi_read(32'h1111_1107, 3'b000, data, resp);
    chk("unaligned_data", data, 32'hDEAD_BEEF);

    // B backpressure: one extra AW/W pair accepted, then stalled
    @(negedge ACLK);
    AWADDR = 32'h1111_1108; AWVALID = 1; WDATA = 32'h1111_2222; WSTRB = 4'hF; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    chk("bp_bvalid", {31'd0, BVALID}, 1);
    chk("bp_awready_open", {31'd0, AWREADY}, 1);
    AWADDR = 32'h1111_110C; AWVALID = 1; WDATA = 32'h3333_4444; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    chk("bp_wready_closed", {31'd0, WREADY}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_bvalid_hold", {31'd0, BVALID}, 1);
      chk("bp_bresp_hold", {30'd0, BRESP}, 0);
      chk("bp_awready_closed", {31'd0, AWREADY}, 0);
      @(negedge ACLK);
    end
    chk("bp_bvalid_hold_end", {31'd0, BVALID}, 1);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    chk("bp_bvalid_gap", {31'd0, BVALID}, 0);
    @(negedge ACLK);
    chk("bp_second_bvalid", {31'd0, BVALID}, 1);
    chk("bp_awready_reopen", {31'd0, AWREADY}, 1);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    axi_read(32'h1111_1108, 3'b000, data, resp);
    chk("bp_reg2", data, 32'h1111_2222);
    axi_read(32'h1111_110C, 3'b000, data, resp);
    chk("bp_reg3", data, 32'h3333_4444);

    // Commit and read of the same register on one edge
    @(negedge ACLK);
    AWADDR = 32'h1111_1108; AWVALID = 1; WDATA = 32'h5555_6666; WSTRB = 4'hF; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'h1111_1108; ARPROT = 0; ARVALID = 1;
    chk("coll_arready", {31'd0, ARREADY}, 1);
    @(negedge ACLK);
    ARVALID = 0;
    chk("coll_rvalid", {31'd0, RVALID}, 1);
    chk("coll_bvalid", {31'd0, BVALID}, 1);
    chk("coll_old_data", RDATA, 32'h1111_2222);
    RREADY = 1; BREADY = 1;
    @(negedge ACLK);
    RREADY = 0; BREADY = 0;
    axi_read(32'h1111_1108, 3'b000, data, resp);
    chk("coll_new_data", data, 32'h5555_6666);

    // Reset with a read pending and a W entry buffered
    @(negedge ACLK);
    WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1;
    @(negedge ACLK);
    WVALID = 0;
    ARADDR = 32'h1111_111C; ARVALID = 1;
    @(negedge ACLK);
    ARVALID = 0;
    chk("mid_rvalid", {31'd0, RVALID}, 1);
    ARESETn = 0;
    @(negedge ACLK);
    chk("mid_rst_rvalid", {31'd0, RVALID}, 0);
    chk("mid_rst_rdata", RDATA, 0);
    chk("mid_rst_awready", {31'd0, AWREADY}, 0);
    ARESETn = 1;
    @(negedge ACLK);
    AWADDR = 32'h1111_1104; AWVALID = 1;
    @(negedge ACLK);
    AWVALID = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_w_discarded", {31'd0, BVALID}, 0);
      @(negedge ACLK);
    end
    WDATA = 32'h0000_00AA; WSTRB = 4'h1; WVALID = 1;
    @(negedge ACLK);
    WVALID = 0;
    @(negedge ACLK);
    chk("mid_after_bvalid", {31'd0, BVALID}, 1);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    axi_read(32'h1111_1104, 3'b000, data, resp);
    chk("mid_reg1", data, 32'h0000_00AA);
    axi_read(32'h1111_1108, 3'b000, data, resp);
    chk("mid_reg2_cleared", data, 0);
    axi_read(32'h1111_111C, 3'b000, data, resp);
    chk("mid_reg7_cleared", data, 0);

`ifdef AXIL_SLAVE_REGFILE_PROT_EN
    axi_write(32'h1111_1100, 32'hFFFF_FFFF, 4'hF, 3'b010, resp);
    chk("prot_bresp", {30'd0, resp}, 2);
    axi_read(32'h1111_1100, 3'b010, data, resp);
    chk("prot_rresp", {30'd0, resp}, 2);
    chk("prot_rdata", data, 0);
    axi_read(32'h1111_1100, 3'b000, data, resp);
    chk("prot_secure_data", data, 0);
    chk("prot_secure_rresp", {30'd0, resp}, 0);
`else
    axi_write(32'h1111_1100, 32'hFFFF_FFFF, 4'hF, 3'b010, resp);
    chk("noprot_bresp", {30'd0, resp}, 0);
    axi_read(32'h1111_1100, 3'b010, data, resp);
    chk("noprot_rresp", {30'd0, resp}, 0);
    chk("noprot_rdata", data, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
